pe_operand_sender: RTL
======================

Name: pe_operand_sender

Overview:
- Source-side driver for the systolic PE array input path. On a start pulse it reads operand matrix A (X×N) and matrix B (N×Y) from two single-port operand RAMs.
- It replays them as the Xin and Yin valid/data streams that the array's input-FIFO write sequencer consumes: A row-major on Xin, B row-major on Yin.
- It then waits for the array's cal_done, reports done, and returns to idle.
- It guarantees the idle gap on Xin_val/Yin_val needed for rising-edge detection between jobs.

Parameters:
- X, 3, rows of A / PE rows
- N, 3, inner dimension (A columns, B rows)
- Y, 3, columns of B / PE columns
- IN_LEN, 8, operand data width
- ADDR_WIDTH, 8, operand RAM address width

Ports:
- clk  in  1  system clock; all logic on rising edge
- sys_rst  in  1  synchronous, active-high reset
- start  in  1  job request pulse; sampled only in IDLE
- a_base  in  ADDR_WIDTH  base address of A; captured on accepted start
- b_base  in  ADDR_WIDTH  base address of B; captured on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at job completion
- a_rd_en  out  1  A RAM read enable
- a_addr  out  ADDR_WIDTH  A RAM read address
- a_rdata  in  IN_LEN  A RAM data; valid 1 cycle after a_rd_en
- b_rd_en  out  1  B RAM read enable
- b_addr  out  ADDR_WIDTH  B RAM read address
- b_rdata  in  IN_LEN  B RAM data; valid 1 cycle after b_rd_en
- Xin_val  out  1  A stream valid
- Xin_data  out  IN_LEN  A stream element
- Yin_val  out  1  B stream valid
- Yin_data  out  IN_LEN  B stream element
- cal_done  in  1  array calculation-complete pulse

Behaviour:
- Reset: every output is 0. State is IDLE and all counters are 0. Reset has priority over all inputs and takes effect mid-job: streams drop the next cycle and no done is issued.
- States: IDLE, ISSUE, DRAIN, WAIT_CAL.
- IDLE:
  - start=1 captures a_base and b_base and clears a_cnt and b_cnt.
  - Next state is ISSUE; busy=1 from the next cycle.
- ISSUE:
  - a_rd_en=1 while a_cnt<X*N, with a_addr=a_base+a_cnt.
  - b_rd_en=1 while b_cnt<N*Y, with b_addr=b_base+b_cnt.
  - Each counter increments when its rd_en is high.
  - Address addition is modulo 2^ADDR_WIDTH (wrap, no error).
  - Both streams start in the same cycle. ISSUE lasts max(X*N, N*Y) cycles, and the shorter stream's rd_en drops early.
  - Then go to DRAIN.
- Stream pipeline: fixed 2-cycle latency from rd_en to the stream.
  - Cycle c: rd_en asserted.
  - Cycle c+1: rdata valid.
  - Cycle c+2: Xin_val/Xin_data (or Yin_val/Yin_data) registered and visible.
  - Data outputs hold their last value when val=0.
  - Xin_val is contiguous for exactly X*N cycles; Yin_val is contiguous for exactly N*Y cycles; no bubbles.
- Stream element order:
  - Xin element k = A[k/N][k%N].
  - Yin element k = B[k/Y][k%Y].
- DRAIN: hold 2 cycles so both val outputs return to 0, then go to WAIT_CAL.
- WAIT_CAL:
  - On cal_done=1: done=1 for that single cycle, busy=0 in the same cycle, next state IDLE.
  - The earliest new start is accepted in the cycle after done. This guarantees at least 3 idle cycles of Xin_val between jobs.
- Ignored inputs:
  - start while not IDLE is ignored; it is not queued.
  - cal_done outside WAIT_CAL is ignored.
  - start and cal_done arriving together in WAIT_CAL: done completes and start is ignored.
- No timeout; WAIT_CAL waits indefinitely.
- Counter width is at least clog2(max(X*N, N*Y)+1).
- Target size: about 150–250 lines of RTL.

Test Plan:
- Defaults (X=N=Y=3). A RAM[0..8]=1..9, B RAM[16..24]=10..18. start with a_base=0, b_base=16 sampled at cycle 0.
  - a_rd_en/b_rd_en high cycles 1–9, addresses 0..8 and 16..24.
  - Xin_val and Yin_val high cycles 3–11, data 1..9 and 10..18.
  - busy=1 from cycle 1.
- X=2, N=3, Y=4:
  - a_rd_en high 6 cycles, b_rd_en high 12 cycles.
  - Xin_val high cycles 3–8, Yin_val high cycles 3–14.
  - DRAIN ends after cycle 14; WAIT_CAL entered.
- cal_done pulsed during ISSUE, then again at cycle 20:
  - The first pulse is ignored.
  - done=1 only at cycle 20 and busy=0 at cycle 20.
  - A start at cycle 21 is accepted.
- start pulsed at cycles 5 and 12 during a job: no restart, counters and addresses undisturbed, exactly one done.
- a_base=254, ADDR_WIDTH=8: a_addr sequence is 254, 255, 0, 1, …, 6 (wrap). Xin data follows RAM contents at those addresses.
- sys_rst asserted at cycle 5 of ISSUE:
  - The next cycle shows all outputs 0 and state IDLE.
  - A later cal_done produces no done.
  - A new start yields a full-length job.

Source files
------------

// File: rtl/pe_operand_sender.sv
// pe_operand_sender: reads operand matrices A and B from single-port RAMs and replays
// them as the Xin/Yin streams, then waits for cal_done before reporting done.
module pe_operand_sender #(
    parameter int X          = 3,
    parameter int N          = 3,
    parameter int Y          = 3,
    parameter int IN_LEN     = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] a_base,
    input  logic [ADDR_WIDTH-1:0] b_base,
    output logic                  busy,
    output logic                  done,
    output logic                  a_rd_en,
    output logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [IN_LEN-1:0]     a_rdata,
    output logic                  b_rd_en,
    output logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [IN_LEN-1:0]     b_rdata,
    output logic                  Xin_val,
    output logic [IN_LEN-1:0]     Xin_data,
    output logic                  Yin_val,
    output logic [IN_LEN-1:0]     Yin_data,
    input  logic                  cal_done
);
    localparam int XN = X * N;
    localparam int NY = N * Y;
    localparam int MX = (XN > NY) ? XN : NY;
    localparam int CW = $clog2(MX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WAIT_CAL} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic [ADDR_WIDTH-1:0] a_base_q, a_base_d, b_base_q, b_base_d;
    logic                  drain_q, drain_d;
    logic                  a_vld_q, b_vld_q;
    logic                  xin_val_q, yin_val_q;
    logic [IN_LEN-1:0]     xin_data_q, yin_data_q;

    always_comb begin
        state_d  = state_q;
        a_cnt_d  = a_cnt_q;
        b_cnt_d  = b_cnt_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        drain_d  = drain_q;
        a_rd_en  = state_q == ISSUE && a_cnt_q < CW'(XN);
        b_rd_en  = state_q == ISSUE && b_cnt_q < CW'(NY);
        a_addr   = a_base_q + ADDR_WIDTH'(a_cnt_q);
        b_addr   = b_base_q + ADDR_WIDTH'(b_cnt_q);
        done     = state_q == WAIT_CAL && cal_done;
        busy     = state_q != IDLE && !done;
        case (state_q)
            IDLE: if (start) begin
                state_d  = ISSUE;
                a_base_d = a_base;
                b_base_d = b_base;
                a_cnt_d  = '0;
                b_cnt_d  = '0;
            end
            ISSUE: begin
                a_cnt_d = a_cnt_q + CW'(a_rd_en);
                b_cnt_d = b_cnt_q + CW'(b_rd_en);
                if (a_cnt_d == CW'(XN) && b_cnt_d == CW'(NY)) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            // two cycles lets the last element leave the 2-stage read pipeline
            DRAIN: begin
                drain_d = 1'b1;
                state_d = drain_q ? WAIT_CAL : DRAIN;
            end
            default: state_d = cal_done ? IDLE : WAIT_CAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            a_cnt_q    <= '0;
            b_cnt_q    <= '0;
            a_base_q   <= '0;
            b_base_q   <= '0;
            drain_q    <= 1'b0;
            a_vld_q    <= 1'b0;
            b_vld_q    <= 1'b0;
            xin_val_q  <= 1'b0;
            yin_val_q  <= 1'b0;
            xin_data_q <= '0;
            yin_data_q <= '0;
        end else begin
            state_q    <= state_d;
            a_cnt_q    <= a_cnt_d;
            b_cnt_q    <= b_cnt_d;
            a_base_q   <= a_base_d;
            b_base_q   <= b_base_d;
            drain_q    <= drain_d;
            a_vld_q    <= a_rd_en;
            b_vld_q    <= b_rd_en;
            xin_val_q  <= a_vld_q;
            yin_val_q  <= b_vld_q;
            xin_data_q <= a_vld_q ? a_rdata : xin_data_q;
            yin_data_q <= b_vld_q ? b_rdata : yin_data_q;
        end
    end

    assign Xin_val  = xin_val_q;
    assign Yin_val  = yin_val_q;
    assign Xin_data = xin_data_q;
    assign Yin_data = yin_data_q;
endmodule
